// File: rtl/unified_memory_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (IF) and data memory (DM).
// DM wins by default; a grant-streak counter forces an IF win so fetch keeps making progress.
module unified_memory_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [XLEN-1:0]     if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [XLEN/8-1:0]   dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [XLEN-1:0]     dm_wdata,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [XLEN-1:0]     dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                busy
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          owner_dm_q, owner_dm_d;
  logic [SW-1:0] streak_q, streak_d;

  logic any_req;
  logic sel_dm;
  logic issue;
  logic grant;
  logic resp;

  // Winner is only computed in IDLE; once a request is out, the latched owner steers everything.
  always_comb begin
    any_req = if_req | dm_req;
    if (state_q == S_IDLE) begin
      sel_dm = dm_req && !(if_req && (streak_q == STREAK_MAX));
    end else begin
      sel_dm = owner_dm_q;
    end
    issue = ((state_q == S_IDLE) && any_req) || (state_q == S_REQ);
    grant = issue && mem_gnt;
    resp  = (state_q == S_RESP) && mem_rvalid;
  end

  // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    owner_dm_d = owner_dm_q;
    streak_d   = streak_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_dm_d = sel_dm;
          state_d    = mem_gnt ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt) state_d = S_RESP;
      end
      S_RESP: begin
        if (mem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The streak only counts DM wins that actually kept a waiting IF out.
    if (grant) begin
      if (sel_dm && if_req) begin
        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
      end else begin
        streak_d = '0;
      end
    end
  end

  // Outputs are forced to zero for the whole reset cycle, independent of the state register.
  always_comb begin
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b0;
    dm_rdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;

    if (!reset) begin
      busy    = (state_q != S_IDLE);
      mem_req = issue;
      if (issue) begin
        if (sel_dm) begin
          mem_we    = dm_we;
          mem_be    = dm_be;
          mem_addr  = dm_addr;
          mem_wdata = dm_wdata;
        end else begin
          mem_be    = '1;
          mem_addr  = if_addr;
        end
      end
      if_gnt    = grant && !sel_dm;
      dm_gnt    = grant &&  sel_dm;
      if_rvalid = resp  && !owner_dm_q;
      dm_rvalid = resp  &&  owner_dm_q;
      if_rdata  = if_rvalid ? mem_rdata : '0;
      dm_rdata  = dm_rvalid ? mem_rdata : '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_dm_q <= 1'b0;
      streak_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_dm_q <= owner_dm_d;
      streak_q   <= streak_d;
    end
  end

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Directed bench for unified_memory_arbiter: a small memory model answers requests and
// per-requester queues hold the read data each response must carry.
module tb_unified_memory_arbiter;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_rvalid;
  logic [XLEN-1:0]   if_rdata;
  logic              dm_req, dm_we;
  logic [3:0]        dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [XLEN-1:0]   dm_wdata;
  logic              dm_gnt, dm_rvalid;
  logic [XLEN-1:0]   dm_rdata;
  logic              mem_req, mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_gnt, mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;
  logic              busy;

  unified_memory_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: mem_gnt follows gnt_en, response one cycle after the grant when auto_rv=1.
  logic            gnt_en, auto_rv, force_rv, preload;
  logic [XLEN-1:0] mem_arr [0:1023];
  logic            rv_pend;
  logic [XLEN-1:0] rd_q;

  assign mem_gnt    = gnt_en;
  assign mem_rvalid = rv_pend | force_rv;
  assign mem_rdata  = rv_pend ? rd_q : (force_rv ? 32'hBAD0BAD0 : 32'h0);

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem_arr[i] <= (i == 0) ? 32'hDEADBEEF : (32'hA5000000 | 32'(i));
      rv_pend <= 1'b0;
    end else begin
      rv_pend <= mem_req && mem_gnt && auto_rv;
      if (mem_req && mem_gnt) begin
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem_arr[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
          rd_q <= 32'h0;
        end else begin
          rd_q <= mem_arr[mem_addr[11:2]];
        end
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard queues and grant-order log.
  logic [XLEN-1:0] if_exp[$];
  logic [XLEN-1:0] dm_exp[$];
  bit              gnt_log[$];
  bit              log_en = 1'b0;
  logic            if_wait = 1'b0, dm_wait = 1'b0;
  logic [XLEN-1:0] mon_e;

  always @(negedge clk) begin
    if (reset) begin
      if_wait <= 1'b0;
      dm_wait <= 1'b0;
    end else begin
      if (if_rvalid) begin
        if (if_exp.size() == 0) check("if_rvalid_unexpected", 64'(if_rvalid), 64'(0));
        else begin
          mon_e = if_exp.pop_front();
          check("if_rdata_sb", 64'(if_rdata), 64'(mon_e));
        end
      end
      if (dm_rvalid) begin
        if (dm_exp.size() == 0) check("dm_rvalid_unexpected", 64'(dm_rvalid), 64'(0));
        else begin
          mon_e = dm_exp.pop_front();
          check("dm_rdata_sb", 64'(dm_rdata), 64'(mon_e));
        end
      end
      // A requester must hold its request until granted.
      if (if_wait) check("if_req_held", 64'(if_req), 64'(1));
      if (dm_wait) check("dm_req_held", 64'(dm_req), 64'(1));
      if_wait <= if_req && !if_gnt;
      dm_wait <= dm_req && !dm_gnt;
      if (log_en) begin
        if (if_gnt) gnt_log.push_back(1'b0);
        if (dm_gnt) gnt_log.push_back(1'b1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit want_dm, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (want_dm ? dm_gnt : if_gnt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [ADDR_W-1:0] dm_a  [8] = '{12'h100, 12'h104, 12'h108, 12'h10C, 12'h100, 12'h104, 12'h108, 12'h10C};
  logic              dm_w  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [3:0]        dm_b  [8] = '{4'hF, 4'h3, 4'hC, 4'h5, 4'hF, 4'hF, 4'hF, 4'hF};
  logic [XLEN-1:0]   dm_d  [8] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [XLEN-1:0]   dm_x  [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h11111111, 32'hA5002222, 32'h33330042, 32'hA5440044};
  bit                exp_order [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    bit ok_if, ok_dm;
    // Reset with every input active: outputs must stay zero.
    reset = 1'b1; preload = 1'b1; gnt_en = 1'b1; auto_rv = 1'b1; force_rv = 1'b1;
    if_req = 1'b1; if_addr = 12'h4;
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF; dm_addr = 12'h8; dm_wdata = 32'hFFFFFFFF;
    tick();
    tick();
    @(negedge clk);
    check("reset_outputs_zero", 64'(|{if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
                                      mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy}), 64'(0));
    tick();
    reset = 1'b0; preload = 1'b0; force_rv = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = '0; dm_wdata = '0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_mem_req", 64'(mem_req), 64'(0));

    // 1: IF-only read, zero-wait grant, data the next cycle.
    tick();
    if_req = 1'b1; if_addr = 12'h0; if_exp.push_back(32'hDEADBEEF);
    @(negedge clk);
    check("t1_if_gnt", 64'(if_gnt), 64'(1));
    check("t1_mem_req", 64'(mem_req), 64'(1));
    check("t1_mem_be", 64'(mem_be), 64'(4'hF));
    check("t1_mem_we", 64'(mem_we), 64'(0));
    check("t1_dm_gnt", 64'(dm_gnt), 64'(0));
    tick();
    if_req = 1'b0;
    @(negedge clk);
    check("t1_if_rvalid", 64'(if_rvalid), 64'(1));
    check("t1_if_rdata", 64'(if_rdata), 64'(32'hDEADBEEF));
    tick();
    @(negedge clk);
    check("t1_busy_after", 64'(busy), 64'(0));
    check("t1_if_rvalid_after", 64'(if_rvalid), 64'(0));

    // 2: simultaneous requests with streak 0, DM write wins.
    tick();
    if_req = 1'b1; if_addr = 12'h20; if_exp.push_back(32'hA5000008);
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 12'h10; dm_wdata = 32'h1234;
    dm_exp.push_back(32'h0);
    @(negedge clk);
    check("t2_dm_gnt", 64'(dm_gnt), 64'(1));
    check("t2_if_gnt", 64'(if_gnt), 64'(0));
    check("t2_mem_we", 64'(mem_we), 64'(1));
    check("t2_mem_be", 64'(mem_be), 64'(4'b0011));
    check("t2_mem_addr", 64'(mem_addr), 64'(12'h10));
    check("t2_mem_wdata", 64'(mem_wdata), 64'(32'h1234));
    tick();
    dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    check("t2_dm_ack", 64'(dm_rvalid), 64'(1));
    check("t2_if_gnt_resp", 64'(if_gnt), 64'(0));
    check("t2_mem_req_resp", 64'(mem_req), 64'(0));
    tick();
    @(negedge clk);
    check("t2_if_gnt_next", 64'(if_gnt), 64'(1));
    check("t2_if_mem_addr", 64'(mem_addr), 64'(12'h20));
    check("t2_if_mem_we", 64'(mem_we), 64'(0));
    tick();
    if_req = 1'b0;
    tick();

    // 4: memory stalls in REQ while DM requests; IF keeps ownership.
    gnt_en = 1'b0;
    if_req = 1'b1; if_addr = 12'h8; if_exp.push_back(32'hA5000002);
    @(negedge clk);
    check("t4_mem_req_idle", 64'(mem_req), 64'(1));
    check("t4_if_gnt_low", 64'(if_gnt), 64'(0));
    tick();
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 12'h10; dm_exp.push_back(32'hA5001234);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_hold_addr", 64'(mem_addr), 64'(12'h8));
      check("t4_hold_gnts", 64'({if_gnt, dm_gnt}), 64'(0));
      check("t4_hold_busy", 64'(busy), 64'(1));
      tick();
    end
    gnt_en = 1'b1;
    @(negedge clk);
    check("t4_if_gnt", 64'(if_gnt), 64'(1));
    check("t4_dm_gnt_none", 64'(dm_gnt), 64'(0));
    tick();
    if_req = 1'b0;
    @(negedge clk);
    check("t4_single_pulse", 64'({if_gnt, dm_gnt}), 64'(0));
    tick();
    @(negedge clk);
    check("t4_dm_gnt_after", 64'(dm_gnt), 64'(1));
    tick();
    dm_req = 1'b0;
    tick();

    // 3: both held continuously; the streak forces IF after four DM grants.
    log_en = 1'b1;
    fork
      begin
        if_req = 1'b1; if_addr = 12'h0; if_exp.push_back(32'hDEADBEEF);
        wait_gnt(1'b0, ok_if);
        check("t3_if_gnt_1", 64'(ok_if), 64'(1));
        tick();
        if_addr = 12'h4; if_exp.push_back(32'hA5000001);
        wait_gnt(1'b0, ok_if);
        check("t3_if_gnt_2", 64'(ok_if), 64'(1));
        tick();
        if_req = 1'b0;
      end
      begin
        for (int k = 0; k < 8; k++) begin
          dm_req = 1'b1; dm_we = dm_w[k]; dm_be = dm_b[k]; dm_addr = dm_a[k]; dm_wdata = dm_d[k];
          dm_exp.push_back(dm_x[k]);
          wait_gnt(1'b1, ok_dm);
          check("t3_dm_gnt", 64'(ok_dm), 64'(1));
          tick();
        end
        dm_req = 1'b0; dm_we = 1'b0;
      end
    join
    tick();
    tick();
    log_en = 1'b0;
    check("t3_grant_count", 64'(gnt_log.size()), 64'(10));
    for (int k = 0; k < 10; k++) begin
      if (k < gnt_log.size()) check("t3_grant_order", 64'(gnt_log[k]), 64'(exp_order[k]));
    end
    check("t3_if_queue_empty", 64'(if_exp.size()), 64'(0));
    check("t3_dm_queue_empty", 64'(dm_exp.size()), 64'(0));

    // 5: reset in RESP, then a late memory response.
    auto_rv = 1'b0;
    if_req = 1'b1; if_addr = 12'hC; if_exp.push_back(32'hA5000003);
    @(negedge clk);
    check("t5_if_gnt", 64'(if_gnt), 64'(1));
    tick();
    if_req = 1'b0; reset = 1'b1;
    if_exp.delete();
    @(negedge clk);
    check("t5_reset_outputs_zero", 64'(|{if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
                                         mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy}), 64'(0));
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t5_idle_after_reset", 64'(busy), 64'(0));
    tick();
    force_rv = 1'b1;
    @(negedge clk);
    check("t5_late_rvalid", 64'({if_rvalid, dm_rvalid}), 64'(0));
    check("t5_late_rdata", 64'(if_rdata), 64'(0));
    check("t5_busy", 64'(busy), 64'(0));
    tick();
    force_rv = 1'b0; auto_rv = 1'b1;

    // 6: spurious memory response in IDLE with nobody requesting.
    tick();
    force_rv = 1'b1;
    @(negedge clk);
    check("t6_rvalids", 64'({if_rvalid, dm_rvalid}), 64'(0));
    check("t6_if_rdata", 64'(if_rdata), 64'(0));
    check("t6_dm_rdata", 64'(dm_rdata), 64'(0));
    tick();
    force_rv = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
